ifetch_buf: RTL and testbench
=============================

# ifetch_buf

Parametrised instruction-fetch stage with a program counter, a fixed-latency memory request port, a DEPTH-entry fetch queue, and branch redirect/flush. It sits between instruction memory and decode. It generates sequential fetch addresses and buffers returned instructions with their PCs. It absorbs decode stalls without losing in-flight responses and discards wrong-path instructions on redirect.

## Interface
Parameters:
- WORD, 32: instruction width.
- ADDR, 32: address/PC width; word-addressed, PC increments by 1.
- DEPTH, 4: queue entries; power of 2, ≥2.
- RESET_PC, 0: PC value after reset.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- req_o  out  1  fetch request this cycle.
- addr_o  out  ADDR  fetch address, equal to current PC.
- v_i  in  1  response valid; memory asserts it exactly one cycle after each req_o.
- inst_i  in  WORD  response instruction.
- branch_i  in  1  redirect request from a later stage.
- baddr_i  in  ADDR  redirect target.
- v_o  out  1  queue head valid.
- inst_o  out  WORD  queue head instruction.
- pc_o  out  ADDR  queue head PC.
- stall_i  in  1  decode cannot accept the head this cycle.
- stall_o  out  1  fetch blocked by lack of queue credit.
- flush_cnt_o  out  16  discarded-instruction count (see Configuration).

## Operation
- State:
  - pc
  - queue: DEPTH entries of {inst, pc}, with head/tail pointers of log2(DEPTH) bits that wrap modulo DEPTH
  - count: 0..DEPTH
  - inflight bit, and inflight_pc holding the address of the outstanding request
- Dequeue (deq) = v_o & ~stall_i. v_o = (count != 0). inst_o/pc_o are driven combinationally from the head entry.
- Credit: credit_ok = (count − deq + inflight) < DEPTH.
- Issue: req_o = rst & ~branch_i & credit_ok.
  - On issue, pc <= pc + 1 (wraps at 2^ADDR), inflight <= 1, inflight_pc <= pc. Otherwise inflight <= 0.
- Enqueue: when v_i & inflight & ~branch_i, write {inst_i, inflight_pc} at the tail.
  - v_i while inflight = 0 is ignored.
- stall_o = rst & ~branch_i & ~credit_ok.
- Redirect (branch_i = 1), in the same cycle:
  - count <= 0, head = tail = 0.
  - A response arriving this cycle is dropped; inflight <= 0.
  - pc <= baddr_i; no request is issued.
  - Redirect has priority over enqueue, dequeue and issue.
- Simultaneous enqueue and dequeue: count is unchanged. When count = DEPTH, credit prevents an enqueue without a matching dequeue; an overflow is impossible by construction.
- Reset (asynchronous, including mid-operation):
  - pc = RESET_PC, count = 0, pointers = 0, inflight = 0.
  - v_o = 0, req_o = 0, stall_o = 0, inst_o/pc_o = 0, flush_cnt_o = 0.
  - A response arriving after reset release for a pre-reset request is ignored because inflight = 0.

## Timing
- Request at cycle t → response at t+1 → enqueued at end of t+1 → v_o at t+2. Fetch-to-decode latency is 2.
- With stall_i = 0 continuously, one instruction per cycle is sustained for any DEPTH ≥ 2.
- Branch at cycle t → first request addr_o = baddr_i at t+1 → v_o with pc_o = baddr_i at t+3.
- Stall: the head is held stable while stall_i = 1. Fetch continues until credit is exhausted, then stall_o = 1.

## Configuration
- IFETCH_BUF_STATS_EN defined:
  - On each redirect, flush_cnt_o += count + (v_i & inflight).
  - Saturates at 16'hFFFF; cleared by reset only.
- Not defined: flush_cnt_o is tied to 0 and no counter logic is present.

## Test plan
- Reset release, stall_i = 0, RESET_PC = 0x100: req_o on the first cycle. v_o rises 2 cycles later with pc_o = 0x100, then 0x101, 0x102 on consecutive cycles.
- Hold stall_i = 1 from the first v_o, DEPTH = 4: exactly 4 entries are queued, then stall_o = 1 and req_o = 0. Release stall_i: entries 0x100..0x103 drain in order with no gap, and fetching resumes without losing an instruction.
- Branch with baddr_i = 0x200 while 3 entries are queued and a response is in flight:
  - v_o = 0 the next cycle and the in-flight response is discarded.
  - v_o with pc_o = 0x200 3 cycles after the branch.
  - flush_cnt_o = 4 when stats are enabled, 0 otherwise.
- Simultaneous enqueue and dequeue at count = DEPTH−1 across pointer wrap: count is stable and PCs remain in strict sequence after wrap.
- Assert rst low mid-stream with the queue full: all outputs reach their reset values immediately. The stale v_i after release is ignored, and the first v_o has pc_o = RESET_PC.
- pc at 2^ADDR−1 with ADDR = 8: the next addr_o is 0x00.

Source files
------------

// File: rtl/ifetch_buf_if.sv
// ifetch_buf_if: fetch-stage bus bundle.
//   Memory side : req_o/addr_o out, v_i/inst_i in.
//   Redirect    : branch_i/baddr_i in.
//   Decode side : v_o/inst_o/pc_o out, stall_i in.
//   Status      : stall_o (credit exhausted), flush_cnt_o (discard count).
// modport master is the fetch unit; modport slave is its environment.
interface ifetch_buf_if #(
  parameter int WORD = 32,
  parameter int ADDR = 32
);
  logic            req_o;
  logic [ADDR-1:0] addr_o;
  logic            v_i;
  logic [WORD-1:0] inst_i;
  logic            branch_i;
  logic [ADDR-1:0] baddr_i;
  logic            v_o;
  logic [WORD-1:0] inst_o;
  logic [ADDR-1:0] pc_o;
  logic            stall_i;
  logic            stall_o;
  logic [15:0]     flush_cnt_o;

  modport master (
    output req_o, addr_o, v_o, inst_o, pc_o, stall_o, flush_cnt_o,
    input  v_i, inst_i, branch_i, baddr_i, stall_i
  );

  modport slave (
    input  req_o, addr_o, v_o, inst_o, pc_o, stall_o, flush_cnt_o,
    output v_i, inst_i, branch_i, baddr_i, stall_i
  );
endinterface

// File: rtl/ifetch_buf.sv
// ifetch_buf: instruction-fetch stage with PC, fixed one-cycle-latency memory
// request port, a DEPTH-entry {inst, pc} queue and branch redirect/flush.
// Ports:
//   clk  - clock, all state updates on posedge
//   rst  - asynchronous active-low reset
//   bus  - ifetch_buf_if.master (memory request/response, redirect, decode)
// Optional feature: define IFETCH_BUF_STATS_EN to count instructions discarded
// by redirects on flush_cnt_o (saturating); otherwise flush_cnt_o is 0.
module ifetch_buf #(
  parameter int              WORD     = 32,
  parameter int              ADDR     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [ADDR-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  ifetch_buf_if.master  bus
);

  localparam int              PW      = $clog2(DEPTH);
  localparam logic [PW+1:0]   DEPTH_W = (PW+2)'(DEPTH);

  logic [ADDR-1:0] pc;
  logic [ADDR-1:0] inflight_pc;
  logic            inflight;
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [PW:0]     count;

  logic [WORD-1:0] q_inst [DEPTH];
  logic [ADDR-1:0] q_pc   [DEPTH];

  logic            v_o;
  logic            deq;
  logic            enq;
  logic            issue;
  logic            credit_ok;
  logic [PW+1:0]   occ;

  assign v_o = (count != '0);
  assign deq = v_o & ~bus.stall_i;
  // Occupancy after this cycle's dequeue, counting the slot reserved by the
  // outstanding request; a new request is only safe if that leaves room.
  assign occ       = {1'b0, count} + (PW+2)'(inflight) - (PW+2)'(deq);
  assign credit_ok = (occ < DEPTH_W);
  assign issue     = rst & ~bus.branch_i & credit_ok;
  assign enq       = bus.v_i & inflight & ~bus.branch_i;

  assign bus.req_o   = issue;
  assign bus.addr_o  = pc;
  assign bus.stall_o = rst & ~bus.branch_i & ~credit_ok;
  assign bus.v_o     = v_o;
  // Head fields are masked when empty so stale storage never reaches decode.
  assign bus.inst_o  = v_o ? q_inst[head] : '0;
  assign bus.pc_o    = v_o ? q_pc[head]   : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
    end else if (bus.branch_i) begin
      // Redirect wins over everything: drop queue and any in-flight response.
      pc       <= bus.baddr_i;
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (enq) tail <= tail + PW'(1);
      if (deq) head <= head + PW'(1);
      case ({enq, deq})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
      if (issue) begin
        pc          <= pc + ADDR'(1);
        inflight    <= 1'b1;
        inflight_pc <= pc;
      end else begin
        inflight <= 1'b0;
      end
    end
  end

  // NOTE: queue storage has no reset; validity comes solely from count, and
  // the outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (enq) begin
      q_inst[tail] <= bus.inst_i;
      q_pc[tail]   <= inflight_pc;
    end
  end

`ifdef IFETCH_BUF_STATS_EN
  logic [15:0] flush_cnt;
  logic [16:0] flush_sum;

  // Discarded = queued entries plus a response landing in the redirect cycle.
  assign flush_sum = {1'b0, flush_cnt} + 17'(count) + 17'(bus.v_i & inflight);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_cnt <= '0;
    end else if (bus.branch_i) begin
      flush_cnt <= flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
    end
  end

  assign bus.flush_cnt_o = flush_cnt;
`else
  assign bus.flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ifetch_buf.sv
// tb_ifetch_buf: self-checking bench for ifetch_buf. A queue-based reference
// model tracks the PC, the expected instruction stream and the outstanding
// request; directed phases then randomized traffic, plus an 8-bit-address
// instance for PC wrap.
module tb_ifetch_buf;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h100;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  logic clk;
  logic rst;

  ifetch_buf_if #(.WORD(32), .ADDR(32)) bus ();
  ifetch_buf_if #(.WORD(32), .ADDR(8))  bus8 ();

  ifetch_buf #(.WORD(32), .ADDR(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ifetch_buf #(.WORD(32), .ADDR(8), .DEPTH(2), .RESET_PC(8'h00)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  ent_t        mq[$];
  logic [31:0] m_pc;
  logic        m_infl;
  logic [31:0] m_infl_pc;
  int          m_flush;

  // Memory responder state
  logic        mem_v;
  logic [31:0] mem_a;
  logic        stale;

  // Last observed outputs, for directed checks
  logic        obs_v, obs_req, obs_stall;
  logic [31:0] obs_pc, obs_addr;
  logic [15:0] obs_flush;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One full clock cycle: drive inputs at negedge, check outputs against the
  // model, advance the model, then let the posedge happen.
  task automatic cycle(input logic st, input logic br, input logic [31:0] ba, input logic spur);
    logic mv, deq, credit, e_req, e_stall;
    int   occ;
    ent_t hd, e;
    logic [31:0] e_flush;
    @(negedge clk);
    bus.stall_i  = st;
    bus.branch_i = br;
    bus.baddr_i  = ba;
    mv           = mem_v | stale | spur;
    bus.v_i      = mv;
    bus.inst_i   = mem_v ? inst_of(mem_a) : $urandom;
    #1;
    hd      = (mq.size() != 0) ? mq[0] : '0;
    deq     = (mq.size() != 0) && !st;
    occ     = mq.size() - int'(deq) + int'(m_infl);
    credit  = (occ < DEPTH);
    e_req   = !br && credit;
    e_stall = !br && !credit;
`ifdef IFETCH_BUF_STATS_EN
    e_flush = m_flush;
`else
    e_flush = 0;
`endif
    check("v_o",         bus.v_o,         mq.size() != 0);
    check("inst_o",      bus.inst_o,      hd.inst);
    check("pc_o",        bus.pc_o,        hd.pc);
    check("req_o",       bus.req_o,       e_req);
    check("addr_o",      bus.addr_o,      m_pc);
    check("stall_o",     bus.stall_o,     e_stall);
    check("flush_cnt_o", bus.flush_cnt_o, e_flush[15:0]);
    obs_v     = bus.v_o;
    obs_pc    = bus.pc_o;
    obs_req   = bus.req_o;
    obs_addr  = bus.addr_o;
    obs_stall = bus.stall_o;
    obs_flush = bus.flush_cnt_o;
    // Memory answers exactly one cycle after each request.
    mem_v = bus.req_o;
    mem_a = bus.addr_o;
    stale = 1'b0;
    if (br) begin
      m_flush = m_flush + mq.size() + int'(mv && m_infl);
      if (m_flush > 65535) m_flush = 65535;
      mq.delete();
      m_infl = 1'b0;
      m_pc   = ba;
    end else begin
      if (deq) void'(mq.pop_front());
      if (mv && m_infl) begin
        e.inst = inst_of(m_infl_pc);
        e.pc   = m_infl_pc;
        mq.push_back(e);
      end
      if (e_req) begin
        m_infl    = 1'b1;
        m_infl_pc = m_pc;
        m_pc      = m_pc + 32'd1;
      end else begin
        m_infl = 1'b0;
      end
    end
    @(posedge clk);
  endtask

  task automatic run(input logic st);
    cycle(st, 1'b0, 32'h0, 1'b0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs checked immediately.
  // Released away from any edge, then a stale response is presented.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst          = 1'b0;
    bus.stall_i  = 1'b0;
    bus.branch_i = 1'b0;
    bus.v_i      = 1'b0;
    #1;
    check("rst_v_o",     bus.v_o,         1'b0);
    check("rst_req_o",   bus.req_o,       1'b0);
    check("rst_stall_o", bus.stall_o,     1'b0);
    check("rst_inst_o",  bus.inst_o,      32'h0);
    check("rst_pc_o",    bus.pc_o,        32'h0);
    check("rst_flush",   bus.flush_cnt_o, 16'h0);
    check("rst_addr_o",  bus.addr_o,      RESET_PC);
    mq.delete();
    m_pc    = RESET_PC;
    m_infl  = 1'b0;
    m_flush = 0;
    mem_v   = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst   = 1'b1;
    stale = 1'b1;
  endtask

  initial begin
    rst           = 1'b0;
    bus.stall_i   = 1'b0;
    bus.branch_i  = 1'b0;
    bus.baddr_i   = '0;
    bus.v_i       = 1'b0;
    bus.inst_i    = '0;
    bus8.stall_i  = 1'b0;
    bus8.branch_i = 1'b0;
    bus8.baddr_i  = '0;
    bus8.v_i      = 1'b0;
    bus8.inst_i   = '0;
    mem_v         = 1'b0;
    mem_a         = '0;
    stale         = 1'b0;

    // Streaming after reset: 2-cycle latency, back-to-back PCs
    do_reset();
    run(1'b0);
    check("a_req0",  obs_req,  1'b1);
    check("a_addr0", obs_addr, 32'h100);
    run(1'b0);
    check("a_v1", obs_v, 1'b0);
    for (int i = 0; i < 3; i++) begin
      run(1'b0);
      check("a_v",  obs_v,  1'b1);
      check("a_pc", obs_pc, 32'h100 + 32'(i));
    end

    // Stall from first v_o: fill to DEPTH, then drain with no gap
    do_reset();
    run(1'b0);
    run(1'b0);
    for (int i = 0; i < 6; i++) run(1'b1);
    check("b_stall_o", obs_stall, 1'b1);
    check("b_req_o",   obs_req,   1'b0);
    check("b_head",    obs_pc,    32'h100);
    for (int i = 0; i < 6; i++) begin
      run(1'b0);
      check("b_drain_v",  obs_v,  1'b1);
      check("b_drain_pc", obs_pc, 32'h100 + 32'(i));
    end

    // Branch with 3 queued and a response in flight
    do_reset();
    run(1'b0);
    run(1'b0);
    run(1'b1);
    run(1'b1);
    cycle(1'b0, 1'b1, 32'h200, 1'b0);
    run(1'b0);
    check("c_v_after",  obs_v,    1'b0);
    check("c_req",      obs_req,  1'b1);
    check("c_addr",     obs_addr, 32'h200);
`ifdef IFETCH_BUF_STATS_EN
    check("c_flush", obs_flush, 16'd4);
`else
    check("c_flush", obs_flush, 16'd0);
`endif
    run(1'b0);
    check("c_v_gap", obs_v, 1'b0);
    run(1'b0);
    check("c_v_tgt",  obs_v,  1'b1);
    check("c_pc_tgt", obs_pc, 32'h200);

    // Simultaneous enq/deq at count = DEPTH-1 across pointer wrap
    do_reset();
    run(1'b0);
    run(1'b0);
    run(1'b1);
    run(1'b1);
    for (int i = 0; i < 12; i++) begin
      run(1'b0);
      check("d_v",   obs_v,   1'b1);
      check("d_pc",  obs_pc,  32'h100 + 32'(i));
      check("d_req", obs_req, 1'b1);
    end

    // Reset mid-stream with a full queue, stale response afterwards
    do_reset();
    run(1'b0);
    run(1'b0);
    for (int i = 0; i < 4; i++) run(1'b1);
    check("e_full_stall", obs_stall, 1'b1);
    do_reset();
    run(1'b0);
    check("e_v0", obs_v, 1'b0);
    run(1'b0);
    check("e_v1", obs_v, 1'b0);
    run(1'b0);
    check("e_v2",  obs_v,  1'b1);
    check("e_pc2", obs_pc, RESET_PC);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 99) < 30,
              $urandom_range(0, 99) < 5,
              ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFE : 32'($urandom),
              $urandom_range(0, 19) == 0);
      end
    end

    // PC wrap with ADDR = 8
    @(negedge clk);
    bus8.branch_i = 1'b1;
    bus8.baddr_i  = 8'hFF;
    @(negedge clk);
    bus8.branch_i = 1'b0;
    #1;
    check("g_addr_ff", bus8.addr_o, 8'hFF);
    check("g_req",     bus8.req_o,  1'b1);
    @(negedge clk);
    #1;
    check("g_addr_wrap", bus8.addr_o, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
